// File: rtl/note_detect.sv
// rtl/note_detect.sv - gated tone frequency counter with sequential note/octave table search
module note_detect #(
  parameter int GATE_CYCLES = 50_000_000,
  parameter int TOL         = 3
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        en,
  input  logic        tone_in,
  output logic [3:0]  note,
  output logic [1:0]  octave,
  output logic [31:0] freq_meas,
  output logic        locked,
  output logic        valid
);

  typedef enum logic [1:0] {IDLE, GATE, SEARCH, REPORT} state_t;

  state_t      state, state_nx;
  logic        sync1, sync2, prev;
  logic        rise;
  logic [31:0] gate_cnt;
  logic [31:0] edge_cnt;
  logic [3:0]  cand_note;   // 0..11, table position
  logic [1:0]  cand_oct;
  logic [31:0] base;
  logic [31:0] expected;
  logic [31:0] diff;
  logic        match;
  logic        last_cand;
  logic        gate_done;
  logic        count_ok;

  // 12-entry base table, A=220 .. G#=415
  function automatic logic [31:0] base_of(input logic [3:0] n);
    case (n)
      4'd0:    base_of = 32'd220;
      4'd1:    base_of = 32'd233;
      4'd2:    base_of = 32'd246;
      4'd3:    base_of = 32'd261;
      4'd4:    base_of = 32'd277;
      4'd5:    base_of = 32'd293;
      4'd6:    base_of = 32'd311;
      4'd7:    base_of = 32'd329;
      4'd8:    base_of = 32'd349;
      4'd9:    base_of = 32'd370;
      4'd10:   base_of = 32'd391;
      4'd11:   base_of = 32'd415;
      default: base_of = 32'd0;
    endcase
  endfunction

  assign rise      = sync2 & ~prev;
  assign gate_done = (gate_cnt == 32'(GATE_CYCLES - 1));
  assign last_cand = (cand_oct == 2'd3) && (cand_note == 4'd11);
  // The first two gate cycles only see edges that were already in flight
  // in the synchronizer before the gate opened, so they are not counted.
  assign count_ok  = (state == GATE) && (gate_cnt >= 32'd2);

  // Candidate value = base x (octave+1), built from shifts and one add
  always_comb begin
    base     = base_of(cand_note);
    expected = base;
    case (cand_oct)
      2'd0:    expected = base;
      2'd1:    expected = base << 1;
      2'd2:    expected = base + (base << 1);
      default: expected = base << 2;
    endcase
    diff  = (edge_cnt >= expected) ? (edge_cnt - expected) : (expected - edge_cnt);
    match = (diff <= 32'(TOL));
  end

  // Tone synchronizer plus previous-sample flop for rising-edge detect
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
    end else begin
      sync1 <= tone_in;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nx;
  end

  // Next-state logic; dropping en abandons any measurement
  always_comb begin
    state_nx = state;
    if (!en) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE:    state_nx = GATE;
        GATE:    if (gate_done) state_nx = SEARCH;
        SEARCH:  if (match || last_cand) state_nx = REPORT;
        REPORT:  state_nx = GATE;
        default: state_nx = IDLE;
      endcase
    end
  end

  // Gate timer, saturating edge counter and search index
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      gate_cnt  <= '0;
      edge_cnt  <= '0;
      cand_note <= '0;
      cand_oct  <= '0;
    end else begin
      if (state == GATE && state_nx == GATE) gate_cnt <= gate_cnt + 32'd1;
      else                                   gate_cnt <= '0;

      if (state == IDLE || state == REPORT || state_nx == IDLE)
        edge_cnt <= '0;
      else if (count_ok && rise && edge_cnt != 32'hFFFF_FFFF)
        edge_cnt <= edge_cnt + 32'd1;

      if (state == SEARCH && state_nx == SEARCH) begin
        if (cand_note == 4'd11) begin
          cand_note <= '0;
          cand_oct  <= cand_oct + 2'd1;
        end else begin
          cand_note <= cand_note + 4'd1;
        end
      end else begin
        cand_note <= '0;
        cand_oct  <= '0;
      end
    end
  end

  // Result registers load as the search ends, so they are valid in REPORT
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      note      <= '0;
      octave    <= '0;
      freq_meas <= '0;
      locked    <= 1'b0;
      valid     <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (state == SEARCH && state_nx == REPORT) begin
        note      <= match ? (cand_note + 4'd1) : 4'd0;
        octave    <= match ? cand_oct : 2'd0;
        freq_meas <= edge_cnt;
        locked    <= match;
        valid     <= 1'b1;
      end
    end
  end

endmodule
